// File: rtl/pixel_ring_pkg.sv
// Shared constants, sweep-state encoding and tap slicing helper for the
// pixel/intensity tapped delay ring.
package pixel_ring_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_TAP_DISTANCE = 1024;
  localparam int DEF_NUM_TAPS     = 8;

  // SWEEP: segment RAMs are being zeroed, shifts refused.
  // RUN:   ring is clean and accepts shifts.
  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } sweep_state_e;

  // Bit offset of tap k inside the flattened tap bus.
  function automatic int unsigned tap_slice(input int unsigned k,
                                            input int unsigned width = DEF_WIDTH);
    return k * width;
  endfunction

endpackage

// File: rtl/ring_segment_ram.sv
// One segment of the tap ring: simple dual-port RAM with a single write port
// and a registered read port that reads every cycle. RAM_STYLE selects the
// implementation hint handed to synthesis.
module ring_segment_ram #(
  parameter int    WIDTH     = 32,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 10,
  parameter string RAM_STYLE = "block"
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  if (RAM_STYLE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port plus read-old-data registered read port.
    always_ff @(posedge i_clk) begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port plus read-old-data registered read port.
    always_ff @(posedge i_clk) begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/pixel_tap_ring.sv
// Tapped delay line for the Type 30 CRT pixel/intensity store. NUM_TAPS RAM
// segments of TAP_DISTANCE words are chained; every accepted shift pushes
// one word in and updates every tap register on the same edge. A clear
// sweep zeroes all segment RAMs after reset or on request.
//
// Timing trick: the RAM read for the *next* shift is issued one edge early
// (address derived from the next write pointer), so the tap registers just
// capture the already-registered RAM output when the shift arrives. When
// that lookahead read hits the address being written on the same edge, the
// written word is captured in a bypass register and used instead.
module pixel_tap_ring
  import pixel_ring_pkg::*;
#(
  parameter int    WIDTH        = DEF_WIDTH,
  parameter int    TAP_DISTANCE = DEF_TAP_DISTANCE,
  parameter int    NUM_TAPS     = DEF_NUM_TAPS,
  parameter string RAM_STYLE    = "block"
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      shift_en,
  input  logic [WIDTH-1:0]          shiftin,
  output logic [WIDTH-1:0]          shiftout,
  output logic [WIDTH*NUM_TAPS-1:0] taps,
  output logic [NUM_TAPS-1:0]       tap_valid,
  output logic                      ready
);

  localparam int AW      = (TAP_DISTANCE > 1) ? $clog2(TAP_DISTANCE) : 1;
  localparam int FULL    = NUM_TAPS * TAP_DISTANCE;
  localparam int CW      = $clog2(FULL + 1);
  localparam logic [AW-1:0] LAST    = AW'(TAP_DISTANCE - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FULL);

  // Pointer increment with wrap at TAP_DISTANCE-1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + AW'(1);
  endfunction

  // Shift count increment, saturating at the full ring length.
  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  sweep_state_e     r_state;
  logic [AW-1:0]    r_sweep_addr;
  logic [AW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic [WIDTH-1:0] r_tap [NUM_TAPS];
  logic [NUM_TAPS-1:0] r_tap_valid;
  logic             r_byp_sel;
  logic [WIDTH-1:0] r_byp_data [NUM_TAPS];

  logic             w_shift;
  logic             w_sweep_wr;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [AW-1:0]    w_raddr;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_wdata [NUM_TAPS];
  logic [WIDTH-1:0] w_ram_q [NUM_TAPS];
  logic [WIDTH-1:0] w_rd    [NUM_TAPS];

  // clear wins over shift_en; nothing is accepted until the sweep is done.
  assign w_shift   = r_ready & shift_en & ~clear;
  assign w_cnt_nxt = cnt_sat_inc(r_cnt);

  // Write side: sweep zeroes, otherwise segment 0 takes shiftin and segment
  // k takes the word leaving tap k-1 on this shift.
  always_comb begin
    w_sweep_wr = clear | (r_state == SWEEP);
    w_we       = reset_n & (w_sweep_wr | w_shift);
    w_waddr    = r_ptr;
    if (clear) begin
      w_waddr = '0;
    end else if (r_state == SWEEP) begin
      w_waddr = r_sweep_addr;
    end
    w_wdata[0] = w_sweep_wr ? '0 : shiftin;
    for (int k = 1; k < NUM_TAPS; k++) begin
      w_wdata[k] = w_sweep_wr ? '0 : r_tap[k-1];
    end
  end

  // Lookahead read address: the slot the next accepted shift will need,
  // i.e. the word written TAP_DISTANCE-1 shifts before it.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (!reset_n || clear) begin
      w_ptr_nxt = '0;
    end else if (w_shift) begin
      w_ptr_nxt = ptr_inc(r_ptr);
    end
    w_raddr = ptr_inc(w_ptr_nxt);
  end

  // Select the bypassed word when the lookahead read collided with a write.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_rd[k] = r_byp_sel ? r_byp_data[k] : w_ram_q[k];
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_seg
    ring_segment_ram #(
      .WIDTH     (WIDTH),
      .DEPTH     (TAP_DISTANCE),
      .ADDR_W    (AW),
      .RAM_STYLE (RAM_STYLE)
    ) u_ram (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata[k]),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_q[k])
    );

    assign taps[tap_slice(k, WIDTH) +: WIDTH] = r_tap[k];
  end

  // Capture same-address write data so the lookahead read never sees stale RAM.
  always_ff @(posedge clock) begin
    r_byp_sel <= w_we && (w_waddr == w_raddr);
    for (int k = 0; k < NUM_TAPS; k++) begin
      r_byp_data[k] <= w_wdata[k];
    end
  end

  // Sweep FSM, ready flag and shared write pointer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= SWEEP;
      r_sweep_addr <= '0;
      r_ready      <= 1'b0;
      r_ptr        <= '0;
    end else if (clear) begin
      // This edge already zeroes address 0; the sweep continues from 1.
      r_state      <= SWEEP;
      r_sweep_addr <= ptr_inc('0);
      r_ready      <= 1'b0;
      r_ptr        <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      case (r_state)
        SWEEP: begin
          if (r_sweep_addr == LAST) begin
            r_state      <= RUN;
            r_sweep_addr <= '0;
            r_ready      <= 1'b1;
          end else begin
            r_sweep_addr <= ptr_inc(r_sweep_addr);
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= SWEEP;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Tap registers, shift count and fill-valid flags move only on accepted shifts.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_cnt       <= '0;
      r_tap_valid <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_tap[k] <= '0;
      end
    end else if (w_shift) begin
      r_cnt <= w_cnt_nxt;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_tap[k]       <= w_rd[k];
        r_tap_valid[k] <= (w_cnt_nxt >= CW'((k + 1) * TAP_DISTANCE));
      end
    end
  end

  assign shiftout  = r_tap[NUM_TAPS-1];
  assign tap_valid = r_tap_valid;
  assign ready     = r_ready;

endmodule

// File: tb/tb_pixel_tap_ring.sv
// Directed plus randomized bench for pixel_tap_ring (WIDTH=8,
// TAP_DISTANCE=4, NUM_TAPS=3). The reference keeps the list of words
// accepted since the last clear and derives each tap by index arithmetic.
module tb_pixel_tap_ring;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 3;

  logic           clock    = 1'b0;
  logic           reset_n  = 1'b0;
  logic           clear    = 1'b0;
  logic           shift_en = 1'b0;
  logic [W-1:0]   shiftin  = '0;
  logic [W-1:0]   shiftout;
  logic [W*N-1:0] taps;
  logic [N-1:0]   tap_valid;
  logic           ready;

  int checks   = 0;
  int failures = 0;

  // Reference state: words accepted since last clear, and sweep edges seen.
  logic [W-1:0] hist [$];
  int           sweep_edges = 0;

  pixel_tap_ring #(
    .WIDTH        (W),
    .TAP_DISTANCE (D),
    .NUM_TAPS     (N),
    .RAM_STYLE    ("block")
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .shift_en  (shift_en),
    .shiftin   (shiftin),
    .shiftout  (shiftout),
    .taps      (taps),
    .tap_valid (tap_valid),
    .ready     (ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] exp_tap(input int k);
    int idx;
    idx = hist.size() + 1 - (k + 1) * D;
    if (idx >= 1) return hist[idx-1];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] ev;
    ev = '0;
    for (int k = 0; k < N; k++) ev[k] = (hist.size() >= (k + 1) * D);
    chk({tag, " ready"}, 32'(ready), 32'(sweep_edges >= D));
    chk({tag, " tap_valid"}, 32'(tap_valid), 32'(ev));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s tap%0d", tag, k), 32'(taps[k*W +: W]), 32'(exp_tap(k)));
    end
    chk({tag, " shiftout"}, 32'(shiftout), 32'(exp_tap(N-1)));
  endtask

  // Drive one cycle of inputs, advance the reference on the edge, settle.
  task automatic cyc(input logic sh, input logic [W-1:0] d, input logic clr);
    shift_en = sh;
    shiftin  = d;
    clear    = clr;
    @(posedge clock);
    if (!reset_n) begin
      hist.delete();
      sweep_edges = 0;
    end else if (clear) begin
      hist.delete();
      sweep_edges = 1;
    end else if (sweep_edges < D) begin
      sweep_edges++;
    end else if (shift_en) begin
      hist.push_back(shiftin);
    end
    #1;
  endtask

  initial begin
    // Reset held for three cycles.
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'hEE, 1'b0);
      check_all("reset");
    end
    chk("reset taps", 32'(taps), 32'h0);

    // Release: ready after exactly 4 sweep edges; shift pulses ignored.
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, 8'hE0 + 8'(i), 1'b0);
      check_all("release");
      chk($sformatf("release ready edge%0d", i + 1), 32'(ready), 32'(i >= 3));
    end
    chk("release taps", 32'(taps), 32'h0);

    // Continuous fill 0x01..0x0C.
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      check_all("fill");
      if (i == 4) begin
        chk("fill4 tap0", 32'(taps[7:0]), 32'h01);
        chk("fill4 valid", 32'(tap_valid), 32'b001);
      end
    end
    chk("fill12 taps", 32'(taps), 32'h010509);
    chk("fill12 shiftout", 32'(shiftout), 32'h01);
    chk("fill12 valid", 32'(tap_valid), 32'b111);

    // Gapped shifting after a clear.
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      check_all("gap sweep");
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      check_all("gap shift");
      cyc(1'b0, 8'hFF, 1'b0);
      check_all("gap idle");
    end
    chk("gap12 taps", 32'(taps), 32'h010509);

    // Clear mid-stream after 10 more shifts.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'($urandom), 1'b0);
      check_all("pre-clear");
    end
    cyc(1'b0, 8'h00, 1'b1);
    check_all("clear edge");
    chk("clear taps", 32'(taps), 32'h0);
    chk("clear valid", 32'(tap_valid), 32'h0);
    for (int j = 1; j <= 3; j++) begin
      cyc(1'b1, 8'h77, 1'b0);
      check_all("clear sweep");
      chk($sformatf("clear ready edge%0d", j + 1), 32'(ready), 32'(j == 3));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'hA1 + 8'(i), 1'b0);
      check_all("post-clear");
    end
    chk("post-clear taps", 32'(taps), 32'h0000A1);

    // clear and shift_en together: word dropped, sweep restarts.
    cyc(1'b1, 8'h55, 1'b1);
    check_all("prio edge");
    chk("prio ready", 32'(ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h55, 1'b0);
      check_all("prio sweep");
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      check_all("prio shift");
    end
    chk("prio tap0", 32'(taps[7:0]), 32'h10);
    chk("prio valid", 32'(tap_valid), 32'b001);

    // Reset while the sweep is at address 2.
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    reset_n = 1'b0;
    cyc(1'b1, 8'h33, 1'b0);
    check_all("midsweep reset");
    chk("midsweep taps", 32'(taps), 32'h0);
    reset_n = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      cyc(1'b1, 8'h44, 1'b0);
      check_all("midsweep release");
      chk($sformatf("midsweep ready edge%0d", j), 32'(ready), 32'(j >= 4));
    end

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 60) == 0);
      check_all("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
